// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths and FSM state type for the SHA-256 message-schedule controller
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int W_LENGTH = 64;
  localparam int MSG_WORDS = 16;
  localparam int IDX_W = $clog2(W_LENGTH) + 1;
  localparam int ADDR_W = $clog2(W_LENGTH);
  localparam int BLK_W = MSG_WORDS * WORD_W;
  localparam int VEC_W = W_LENGTH * WORD_W;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} sched_state_t;
endpackage

// File: rtl/sha256_sched_ctrl_if.sv
// sha256_sched_ctrl_if: block-in, expansion-datapath and schedule-out handshakes; slave is the controller side
interface sha256_sched_ctrl_if;
  import sha256_pkg::*;
  logic blk_valid;
  logic blk_ready;
  logic [BLK_W-1:0] blk_data;
  logic exp_enable;
  logic [IDX_W-1:0] exp_index;
  logic exp_valid;
  logic [WORD_W-1:0] exp_word;
  logic sched_valid;
  logic sched_ready;
  modport slave (
    input blk_valid, blk_data, exp_valid, exp_word, sched_ready,
    output blk_ready, exp_enable, exp_index, sched_valid
  );
  modport master (
    output blk_valid, blk_data, exp_valid, exp_word, sched_ready,
    input blk_ready, exp_enable, exp_index, sched_valid
  );
endinterface

// File: rtl/sha256_w_regfile.sv
// sha256_w_regfile: 64x32 schedule storage with bulk block load, one indexed write port and a combinational read port
module sha256_w_regfile
  import sha256_pkg::*;
(
  input logic clock,
  input logic reset,
  input logic load,
  input logic [BLK_W-1:0] blk_data,
  input logic wr_en,
  input logic [ADDR_W-1:0] wr_idx,
  input logic [WORD_W-1:0] wr_data,
  input logic [ADDR_W-1:0] rd_idx,
  output logic [WORD_W-1:0] rd_word,
  output logic [VEC_W-1:0] w_vector
);
  logic [WORD_W-1:0] mem [W_LENGTH];
  always_ff @(posedge clock)
    for (int i = 0; i < W_LENGTH; i++)
      if (reset) mem[i] <= '0;
      else if (load) mem[i] <= i < MSG_WORDS ? blk_data[WORD_W*i +: WORD_W] : '0;
      else if (wr_en && wr_idx == ADDR_W'(i)) mem[i] <= wr_data;
  for (genvar g = 0; g < W_LENGTH; g++) begin : g_flat
    assign w_vector[WORD_W*g +: WORD_W] = mem[g];
  end
  assign rd_word = mem[rd_idx];
endmodule

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl: owns the W vector and steps the external expansion datapath through words 16..63.
// SHA256_SCHED_ABORT_EN adds an abort input that drops back to IDLE keeping w_vector intact.
module sha256_sched_ctrl
  import sha256_pkg::*;
(
  input logic clock,
  input logic reset,
`ifdef SHA256_SCHED_ABORT_EN
  input logic abort,
`endif
  sha256_sched_ctrl_if.slave bus,
  input logic [ADDR_W-1:0] rd_index,
  output logic [WORD_W-1:0] rd_word,
  output logic [VEC_W-1:0] w_vector,
  output logic busy
);
  sched_state_t state, state_n;
  logic [IDX_W-1:0] index, index_n;
  logic load, wr_en, last, kill;
`ifdef SHA256_SCHED_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  assign last = index == IDX_W'(W_LENGTH - 1);
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_n;
      index <= index_n;
    end
  // abort outranks a same-cycle exp_valid, so the pending word is never written
  always_comb begin
    state_n = state;
    index_n = index;
    load = 1'b0;
    wr_en = 1'b0;
    if (kill) begin
      state_n = IDLE;
      index_n = '0;
    end else
      case (state)
        IDLE:
          if (bus.blk_valid) begin
            load = 1'b1;
            state_n = EXPAND;
            index_n = IDX_W'(MSG_WORDS);
          end
        EXPAND:
          if (bus.exp_valid) begin
            wr_en = 1'b1;
            state_n = last ? DONE : EXPAND;
            index_n = last ? index : index + 1'b1;
          end
        DONE:
          if (bus.sched_ready) begin
            state_n = IDLE;
            index_n = '0;
          end
        default: begin
          state_n = IDLE;
          index_n = '0;
        end
      endcase
  end
  assign bus.blk_ready = state == IDLE;
  assign bus.exp_enable = state == EXPAND;
  assign bus.exp_index = state == EXPAND ? index : '0;
  assign bus.sched_valid = state == DONE;
  assign busy = state != IDLE;
  sha256_w_regfile u_regfile (
    .clock(clock),
    .reset(reset),
    .load(load),
    .blk_data(bus.blk_data),
    .wr_en(wr_en),
    .wr_idx(index[ADDR_W-1:0]),
    .wr_data(bus.exp_word),
    .rd_idx(rd_index),
    .rd_word(rd_word),
    .w_vector(w_vector)
  );
endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb_sha256_sched_ctrl: scoreboard bench with a golden SHA-256 schedule model acting as the expansion datapath
module tb_sha256_sched_ctrl;
  import sha256_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] rd_index;
  logic [WORD_W-1:0] rd_word;
  logic [VEC_W-1:0] w_vector;
  logic busy;
  logic dp_valid;
`ifdef SHA256_SCHED_ABORT_EN
  logic abort;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [VEC_W-1:0] exp_q[$];
  sha256_sched_ctrl_if bus();
  sha256_sched_ctrl dut (
    .clock(clock),
    .reset(reset),
`ifdef SHA256_SCHED_ABORT_EN
    .abort(abort),
`endif
    .bus(bus.slave),
    .rd_index(rd_index),
    .rd_word(rd_word),
    .w_vector(w_vector),
    .busy(busy)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] next_word(input logic [VEC_W-1:0] v, input int t);
    if (t < 16 || t > 63) return '0;
    return sig1(v[32*(t-2) +: 32]) + v[32*(t-7) +: 32] + sig0(v[32*(t-15) +: 32]) + v[32*(t-16) +: 32];
  endfunction
  function automatic logic [VEC_W-1:0] expand(input logic [BLK_W-1:0] blk);
    logic [VEC_W-1:0] v = '0;
    v[BLK_W-1:0] = blk;
    for (int t = 16; t < 64; t++) v[32*t +: 32] = next_word(v, t);
    return v;
  endfunction
  function automatic logic [BLK_W-1:0] rand_block();
    logic [BLK_W-1:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction
  assign bus.exp_word = next_word(w_vector, int'(bus.exp_index));
  assign bus.exp_valid = dp_valid;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic check_vec(input string tag, input logic [VEC_W-1:0] want, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      check($sformatf("%s[%0d]", tag, i), w_vector[32*i +: 32], want[32*i +: 32]);
  endtask
  task automatic offer(input logic [BLK_W-1:0] blk);
    check("offer_ready", 32'(bus.blk_ready), 32'd1);
    bus.blk_data = blk;
    bus.blk_valid = 1'b1;
    tick();
    bus.blk_valid = 1'b0;
    exp_q.push_back(expand(blk));
  endtask
  task automatic wait_sched(input int exp_lat, input int stall_at, input int stall_len,
                            output logic [VEC_W-1:0] got_exp);
    int c = 1;
    int sc = 0;
    while (!bus.sched_valid && c < 200) begin
      if (sc > 0 && sc <= stall_len) check("stall_hold", 32'(bus.exp_index), 32'(stall_at));
      if (int'(bus.exp_index) == stall_at && sc < stall_len) begin
        dp_valid = 1'b0;
        sc++;
      end else begin
        dp_valid = 1'b1;
        if (sc > 0) sc = stall_len + 1;
      end
      tick();
      c++;
    end
    dp_valid = 1'b1;
    check("latency", 32'(c), 32'(exp_lat));
    check("sched_valid", 32'(bus.sched_valid), 32'd1);
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    got_exp = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    check_vec("sched", got_exp, 0, 63);
  endtask
  task automatic wait_index(input int n);
    int c = 0;
    while (int'(bus.exp_index) != n && c < 100) begin
      tick();
      c++;
    end
    check("reach_idx", 32'(bus.exp_index), 32'(n));
  endtask
  initial begin
    logic [BLK_W-1:0] blk_a, blk_b;
    logic [VEC_W-1:0] va, vb;
    reset = 1'b1;
    dp_valid = 1'b1;
    rd_index = '0;
    bus.sched_ready = 1'b0;
    bus.blk_valid = 1'b1;
    bus.blk_data = rand_block();
`ifdef SHA256_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    bus.blk_valid = 1'b0;
    check("rst_blk_ready", 32'(bus.blk_ready), 32'd1);
    check("rst_sched_valid", 32'(bus.sched_valid), 32'd0);
    check("rst_exp_enable", 32'(bus.exp_enable), 32'd0);
    check("rst_exp_index", 32'(bus.exp_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_w", '0, 0, 63);
    blk_a = '0;
    blk_a[31:0] = 32'h61626380;
    blk_a[511:480] = 32'h00000018;
    offer(blk_a);
    check("acc_exp_enable", 32'(bus.exp_enable), 32'd1);
    check("acc_exp_index", 32'(bus.exp_index), 32'd16);
    check("acc_busy", 32'(busy), 32'd1);
    wait_sched(49, -1, 0, va);
    check("abc_w16", w_vector[32*16 +: 32], 32'h61626380);
    check("abc_w17", w_vector[32*17 +: 32], 32'h000F0000);
    rd_index = 6'd17;
    #1;
    check("rd17", rd_word, 32'h000F0000);
    rd_index = 6'd15;
    #1;
    check("rd15", rd_word, 32'h00000018);
    check("done_exp_index", 32'(bus.exp_index), 32'd0);
    blk_b = rand_block();
    bus.blk_data = blk_b;
    bus.blk_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_sched_valid", 32'(bus.sched_valid), 32'd1);
      check("bp_blk_ready", 32'(bus.blk_ready), 32'd0);
      check("bp_exp_enable", 32'(bus.exp_enable), 32'd0);
    end
    check_vec("bp_stable", va, 0, 63);
    bus.sched_ready = 1'b1;
    tick();
    bus.sched_ready = 1'b0;
    check("hs_blk_ready", 32'(bus.blk_ready), 32'd1);
    check("hs_sched_valid", 32'(bus.sched_valid), 32'd0);
    check("hs_exp_enable", 32'(bus.exp_enable), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    offer(blk_b);
    check("b_exp_index", 32'(bus.exp_index), 32'd16);
    wait_sched(52, 30, 3, vb);
    bus.sched_ready = 1'b1;
    tick();
    bus.sched_ready = 1'b0;
    check("b_release", 32'(bus.blk_ready), 32'd1);
    offer(rand_block());
    wait_index(40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mrst_exp_enable", 32'(bus.exp_enable), 32'd0);
    check("mrst_blk_ready", 32'(bus.blk_ready), 32'd1);
    check("mrst_exp_index", 32'(bus.exp_index), 32'd0);
    check_vec("mrst_w", '0, 0, 63);
`ifdef SHA256_SCHED_ABORT_EN
    blk_a = rand_block();
    offer(blk_a);
    va = exp_q.pop_front();
    wait_index(25);
    abort = 1'b1;
    dp_valid = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_blk_ready", 32'(bus.blk_ready), 32'd1);
    check("ab_exp_enable", 32'(bus.exp_enable), 32'd0);
    check("ab_sched_valid", 32'(bus.sched_valid), 32'd0);
    check("ab_w25", w_vector[32*25 +: 32], 32'd0);
    check_vec("ab_kept", va, 0, 24);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_vec("ab_idle", va, 0, 24);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sha256_sched_ctrl.md
# sha256_sched_ctrl

Controller for the SHA-256 message-schedule expansion stage. Accepts one 512-bit message block over a valid/ready handshake and owns the 64-word W vector. Drives the external expansion datapath one word index at a time (16..63) and writes each returned word into the vector. Presents the completed schedule to the compression stage over a second valid/ready handshake.

## Interface

- W_LENGTH, 64, number of schedule words
- MSG_WORDS, 16, words loaded directly from the message block
- IDX_W, $clog2(W_LENGTH)+1, index width (7 at default)

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- blk_valid  in  1  message block offered
- blk_ready  out  1  controller can accept a block
- blk_data  in  512  word i at bits [32i+31:32i]
- exp_enable  out  1  expansion request active
- exp_index  out  IDX_W  word index being requested
- exp_valid  in  1  exp_word valid for exp_index
- exp_word  in  32  expanded word from the datapath
- w_vector  out  W_LENGTH*32  schedule vector; word i at bits [32i+31:32i]
- sched_valid  out  1  full schedule available
- sched_ready  in  1  compression accepts the schedule
- rd_index  in  6  random-access word select
- rd_word  out  32  combinational word rd_index of w_vector
- busy  out  1  high in EXPAND or DONE

## Operation

- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - blk_ready=1.
  - On blk_valid&&blk_ready: words 0..15 <= blk_data; words 16..63 <= 0; index <= 16; go to EXPAND.
- EXPAND:
  - exp_enable=1; exp_index=index.
  - On exp_valid: word[index] <= exp_word.
  - If index==63, go to DONE; otherwise index <= index+1.
  - Without exp_valid: hold index; exp_enable stays high.
- DONE:
  - sched_valid=1; exp_enable=0; w_vector stable.
  - On sched_ready: go to IDLE; index <= 0.
- exp_index is 0 outside EXPAND.
- The datapath computes from w_vector and exp_index. exp_word must depend only on words below index.
- Ignored inputs:
  - exp_valid outside EXPAND.
  - sched_ready outside DONE.
  - blk_valid outside IDLE.
- rd_word = w_vector[32*rd_index +: 32], purely combinational. Valid in any state.

## Timing

- Reset is synchronous and dominates all other inputs. After reset: state IDLE, blk_ready=1, exp_enable=0, exp_index=0, sched_valid=0, busy=0, w_vector=0.
- Reset mid-EXPAND or mid-DONE: abandon the block and zero w_vector.
- All outputs except rd_word are decoded from registered state; no input-to-output combinational path.
- Block accept edge to exp_enable high: 1 cycle (index 16 presented).
- Cost per word: 1 cycle when exp_valid is held high. Minimum block-accept to sched_valid: 49 cycles (1 + 48 words).
- sched_ready handshake edge to blk_ready high: 1 cycle. Minimum block period: 50 cycles. No back-to-back overlap.
- exp_valid on the index==63 cycle: word 63 written and sched_valid high on the same edge.
- Index arithmetic is IDX_W wide. Never exceeds 63 while in EXPAND.

## Configuration

- SHA256_SCHED_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort in EXPAND or DONE: return to IDLE on the next edge; index <= 0; sched_valid drops.
  - w_vector is retained, not zeroed.
  - abort in IDLE has no effect.
  - Simultaneous abort and exp_valid: abort wins and the word is not written.
  - Simultaneous abort and sched_ready: same resulting state.
- SHA256_SCHED_ABORT_EN undefined: abort port absent; no abort path.

## Structure

- Shared package sha256_pkg holds:
  - WORD_W=32, W_LENGTH, MSG_WORDS.
  - sched_state_t enum {IDLE, EXPAND, DONE}.
- One sub-module: sha256_w_regfile.
  - 64x32 storage.
  - Bulk load of words 0..15 with clear of 16..63.
  - Single indexed write port.
  - Flat w_vector output and combinational rd port.
- The FSM and index counter live in sha256_sched_ctrl.

## Test plan

- Reset: hold reset 2 cycles with blk_valid=1 -> blk_ready=1, sched_valid=0, w_vector=0 after release; no block accepted during reset.
- "abc" block:
  - Stimulus: word0=0x61626380, words1..14=0, word15=0x00000018; golden model answers exp_valid every cycle.
  - Required response: word16=0x61626380, word17=0x000F0000; sched_valid exactly 49 cycles after accept; rd_index=17 reads 0x000F0000.
- Datapath stall: exp_valid low 3 cycles at index 30 -> exp_index held at 30; word 30 written once; sched_valid at cycle 52.
- Backpressure: sched_ready low 10 cycles in DONE -> sched_valid and w_vector stable; blk_ready=0; second block's blk_valid not accepted until 1 cycle after the handshake.
- Reset mid-EXPAND at index 40 -> next cycle IDLE, exp_enable=0, w_vector=0.
- SHA256_SCHED_ABORT_EN, abort with exp_valid at index 25 -> IDLE next cycle; word 25 unchanged (0); words 16..24 retained.
